// File: rtl/float_contract_scheduler.sv
// Round-robin scheduler sharing one fixed-latency float contraction unit among NUM_REQ requesters.
// Credits reserve output FIFO space at issue time, so the shared unit never has to stall.
module float_contract_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int EXP_IN       = 8,
    parameter int FRAC_IN      = 23,
    parameter int EXP_OUT      = 5,
    parameter int FRAC_OUT     = 10,
    parameter int UNIT_LATENCY = 2,
    parameter int DEPTH        = 2,
    localparam int WI = 1 + EXP_IN + FRAC_IN,
    localparam int WO = 1 + EXP_OUT + FRAC_OUT,
    localparam int TW = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    reqValid,
    output logic [NUM_REQ-1:0]    reqReady,
    input  logic [NUM_REQ*WI-1:0] reqData,
    output logic                  unitInValid,
    output logic [WI-1:0]         unitInData,
    output logic [TW-1:0]         unitInTag,
    input  logic                  unitOutValid,
    input  logic [WO-1:0]         unitOutData,
    input  logic [TW-1:0]         unitOutTag,
    output logic [NUM_REQ-1:0]    respValid,
    input  logic [NUM_REQ-1:0]    respReady,
    output logic [NUM_REQ*WO-1:0] respData,
    output logic                  error
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
    localparam logic [PW-1:0] SLOT_LAST  = PW'(DEPTH - 1);
    localparam logic [TW-1:0] REQ_LAST   = TW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || DEPTH < 1 || UNIT_LATENCY < 1) begin : gBadParams
        $error("float_contract_scheduler: unsupported parameter set");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Valid never waits on ready; reqReady is a one-hot grant and never looks at respReady.

    logic [TW-1:0]      ptr;
    logic [CW-1:0]      credit     [NUM_REQ];
    logic [CW-1:0]      creditNext [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] grant;
    logic               grantAny;
    logic [TW-1:0]      grantIdx;
    logic [TW-1:0]      ptrNext;
    logic [WI-1:0]      grantData;

    logic [WO-1:0]      mem   [NUM_REQ][DEPTH];
    logic [PW-1:0]      rdPtr [NUM_REQ];
    logic [PW-1:0]      wrPtr [NUM_REQ];
    logic [CW-1:0]      count [NUM_REQ];
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] wrEn;
    logic [NUM_REQ-1:0] pop;
    logic               tagHit;
    logic               tagFull;
    logic               protoErr;

    // Eligible requesters at or above ptr win first; otherwise wrap to the lowest index.
    always_comb begin
        eligible  = '0;
        upper     = '0;
        grant     = '0;
        grantAny  = 1'b0;
        grantIdx  = '0;
        grantData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = reqValid[i] && (credit[i] < CREDIT_MAX);
            upper[i]    = eligible[i] && (TW'(i) >= ptr);
        end
        pick = (|upper) ? upper : eligible;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grantAny && pick[i]) begin
                grantAny  = 1'b1;
                grant[i]  = 1'b1;
                grantIdx  = TW'(i);
                grantData = reqData[i*WI +: WI];
            end
        end
        ptrNext = (grantIdx == REQ_LAST) ? '0 : grantIdx + TW'(1);
    end

    assign reqReady = grant;

    // A result whose FIFO is full or whose tag names no requester is dropped and flagged.
    always_comb begin
        full     = '0;
        wrEn     = '0;
        tagHit   = 1'b0;
        tagFull  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            full[i] = (count[i] == CREDIT_MAX);
            if (unitOutValid && (unitOutTag == TW'(i))) begin
                tagHit = 1'b1;
                if (full[i]) begin
                    tagFull = 1'b1;
                end else begin
                    wrEn[i] = 1'b1;
                end
            end
        end
        protoErr = unitOutValid && (!tagHit || tagFull);
    end

    always_comb begin
        respValid = '0;
        respData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            respValid[i]         = (count[i] != '0);
            respData[i*WO +: WO] = mem[i][rdPtr[i]];
        end
    end

    assign pop = respValid & respReady;

    // Grant and pop together leave the credit unchanged; the zero guard keeps it from wrapping.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            creditNext[i] = credit[i];
            if (grant[i] && !pop[i]) begin
                creditNext[i] = credit[i] + CW'(1);
            end else if (!grant[i] && pop[i] && (credit[i] != '0)) begin
                creditNext[i] = credit[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr         <= '0;
            unitInValid <= 1'b0;
            unitInData  <= '0;
            unitInTag   <= '0;
            error       <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                credit[i] <= '0;
                rdPtr[i]  <= '0;
                wrPtr[i]  <= '0;
                count[i]  <= '0;
            end
        end else begin
            unitInValid <= grantAny;
            if (grantAny) begin
                unitInData <= grantData;
                unitInTag  <= grantIdx;
                ptr        <= ptrNext;
            end
            if (protoErr) begin
                error <= 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                credit[i] <= creditNext[i];
                if (wrEn[i]) begin
                    wrPtr[i] <= (wrPtr[i] == SLOT_LAST) ? '0 : wrPtr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rdPtr[i] <= (rdPtr[i] == SLOT_LAST) ? '0 : rdPtr[i] + PW'(1);
                end
                case ({wrEn[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage carries no reset: occupancy counts alone decide what is visible.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wrEn[i]) begin
                mem[i][wrPtr[i]] <= unitOutData;
            end
        end
    end

endmodule

// File: tb/tb_float_contract_scheduler.sv
// Directed bench for float_contract_scheduler with a behavioural shared unit and per-requester scoreboard.
`timescale 1ns/1ps
module tb_float_contract_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WI      = 32;
    localparam int WO      = 16;
    localparam int TW      = 2;
    localparam int UL      = 2;
    localparam int DEPTH   = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NUM_REQ-1:0]    reqValid = '0;
    logic [NUM_REQ-1:0]    reqReady;
    logic [NUM_REQ*WI-1:0] reqData = '0;
    logic                  unitInValid;
    logic [WI-1:0]         unitInData;
    logic [TW-1:0]         unitInTag;
    logic                  unitOutValid;
    logic [WO-1:0]         unitOutData;
    logic [TW-1:0]         unitOutTag;
    logic [NUM_REQ-1:0]    respValid;
    logic [NUM_REQ-1:0]    respReady = '0;
    logic [NUM_REQ*WO-1:0] respData;
    logic                  error;

    logic          injEn    = 1'b0;
    logic          injValid = 1'b0;
    logic [WO-1:0] injData  = '0;
    logic [TW-1:0] injTag   = '0;

    float_contract_scheduler #(
        .NUM_REQ(NUM_REQ), .EXP_IN(8), .FRAC_IN(23), .EXP_OUT(5), .FRAC_OUT(10),
        .UNIT_LATENCY(UL), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqData(reqData),
        .unitInValid(unitInValid), .unitInData(unitInData), .unitInTag(unitInTag),
        .unitOutValid(unitOutValid), .unitOutData(unitOutData), .unitOutTag(unitOutTag),
        .respValid(respValid), .respReady(respReady), .respData(respData),
        .error(error)
    );

    // Three-requester instance: a 2-bit tag of 3 names no requester.
    logic [2:0]    reqReady3;
    logic          unitInValid3;
    logic [WI-1:0] unitInData3;
    logic [TW-1:0] unitInTag3;
    logic          unitOutValid3 = 1'b0;
    logic [WO-1:0] unitOutData3  = '0;
    logic [TW-1:0] unitOutTag3   = '0;
    logic [2:0]    respValid3;
    logic [3*WO-1:0] respData3;
    logic          error3;

    float_contract_scheduler #(
        .NUM_REQ(3), .EXP_IN(8), .FRAC_IN(23), .EXP_OUT(5), .FRAC_OUT(10),
        .UNIT_LATENCY(UL), .DEPTH(DEPTH)
    ) dut3 (
        .clock(clock), .reset(reset),
        .reqValid(3'b000), .reqReady(reqReady3), .reqData({3*WI{1'b0}}),
        .unitInValid(unitInValid3), .unitInData(unitInData3), .unitInTag(unitInTag3),
        .unitOutValid(unitOutValid3), .unitOutData(unitOutData3), .unitOutTag(unitOutTag3),
        .respValid(respValid3), .respReady(3'b000), .respData(respData3),
        .error(error3)
    );

    // ---------------- shared unit model ----------------
    function automatic logic [WO-1:0] contract(input logic [WI-1:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (e < 8'd113) return {x[31], 15'h0000};
        if (e > 8'd142) return {x[31], 5'h1f, 10'h000};
        return {x[31], 5'(e - 8'd112), x[22:13]};
    endfunction

    logic          mv [UL];
    logic [WO-1:0] md [UL];
    logic [TW-1:0] mt [UL];

    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < UL; k++) mv[k] <= 1'b0;
        end else begin
            mv[0] <= unitInValid;
            md[0] <= contract(unitInData);
            mt[0] <= unitInTag;
            for (int k = 1; k < UL; k++) begin
                mv[k] <= mv[k-1];
                md[k] <= md[k-1];
                mt[k] <= mt[k-1];
            end
        end
    end

    assign unitOutValid = injEn ? injValid : mv[UL-1];
    assign unitOutData  = injEn ? injData  : md[UL-1];
    assign unitOutTag   = injEn ? injTag   : mt[UL-1];

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [WO-1:0] expQ [NUM_REQ][$];
    int            grantCnt [NUM_REQ];
    int            grantLog [$];
    logic          prevValid = 1'b0;
    logic [TW-1:0] prevTag   = '0;
    logic [WI-1:0] prevData  = '0;

    always @(negedge clock) begin
        #1;
        if (reset) begin
            prevValid = 1'b0;
        end else begin
            checkEq("onehot", 32'($countones(reqReady) <= 1), 32'd1);
            checkEq("issueValid", unitInValid, prevValid);
            if (prevValid) begin
                checkEq("issueTag", unitInTag, prevTag);
                checkEq("issueData", unitInData, prevData);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (respValid[i] && respReady[i]) begin
                    if (expQ[i].size() == 0) checkEq("respSpurious", respValid[i], 0);
                    else checkEq("respData", respData[i*WO +: WO], expQ[i].pop_front());
                end
            end
            prevValid = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reqValid[i] && reqReady[i]) begin
                    prevValid = 1'b1;
                    prevTag   = TW'(i);
                    prevData  = reqData[i*WI +: WI];
                    expQ[i].push_back(contract(reqData[i*WI +: WI]));
                    grantCnt[i]++;
                    grantLog.push_back(i);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] dataTab [8] = '{32'h3F800000, 32'h40000000, 32'hBFC00000, 32'h3E800000,
                                 32'h41200000, 32'hC2C80000, 32'h3F000000, 32'h47000000};

    task automatic doReset();
        reset     = 1'b1;
        reqValid  = '0;
        respReady = '0;
        injEn     = 1'b0;
        injValid  = 1'b0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < NUM_REQ; i++) begin
            expQ[i].delete();
            grantCnt[i] = 0;
        end
        grantLog.delete();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        reqValid  = '0;
        respReady = '1;
        repeat (12) @(negedge clock);
        #3;
        for (int i = 0; i < NUM_REQ; i++) checkEq(tag, expQ[i].size(), 0);
        checkEq(tag, respValid, 0);
        respReady = '0;
        @(negedge clock);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        doReset();

        // idle after reset
        for (int c = 0; c < 5; c++) begin
            #3;
            checkEq("idleRespValid", respValid, 0);
            checkEq("idleUnitInValid", unitInValid, 0);
            checkEq("idleError", error, 0);
            checkEq("idleReqReady", reqReady, 0);
            checkEq("idleUnitInTag", unitInTag, 0);
            checkEq("idleUnitInData", unitInData, 0);
            @(negedge clock);
        end

        // single operand latency: 1.0 -> 16'h3C00
        reqValid = 4'b0001;
        reqData[0 +: WI] = 32'h3F800000;
        #3 checkEq("latGrant", reqReady, 4'b0001);
        @(negedge clock); reqValid = '0;
        #3 checkEq("latIssueValid", unitInValid, 1);
        checkEq("latIssueData", unitInData, 32'h3F800000);
        checkEq("latIssueTag", unitInTag, 0);
        @(negedge clock);
        #3 checkEq("latT2Resp", respValid, 0);
        @(negedge clock);
        #3 checkEq("latUnitOut", {unitOutValid, unitOutTag, unitOutData}, {1'b1, 2'd0, 16'h3C00});
        checkEq("latNoBypass", respValid, 0);
        @(negedge clock);
        #3 checkEq("latRespValid", respValid, 4'b0001);
        checkEq("latRespData", respData[0 +: WO], 16'h3C00);
        @(negedge clock); respReady = 4'b0001;
        #3 checkEq("latHold", respValid, 4'b0001);
        @(negedge clock); respReady = '0;
        #3 checkEq("latPopped", respValid, 0);
        @(negedge clock);

        // round-robin fairness
        doReset();
        for (int c = 0; c < 12; c++) begin
            reqValid  = '1;
            respReady = '1;
            for (int i = 0; i < NUM_REQ; i++) reqData[i*WI +: WI] = dataTab[(c + i) % 8];
            @(negedge clock);
        end
        checkEq("rrCount", grantLog.size(), 12);
        for (int k = 0; k < 12 && k < grantLog.size(); k++) checkEq("rrOrder", grantLog[k], k % 4);
        drain("rrDrain");

        // credit limit on requester 2
        doReset();
        reqData[2*WI +: WI] = dataTab[4];
        for (int c = 0; c < 12; c++) begin
            reqValid = 4'b0100;
            #3 checkEq("credReady", reqReady[2], c < 2);
            @(negedge clock);
        end
        checkEq("credGrants", grantCnt[2], 2);
        respReady = 4'b0100;
        reqData[2*WI +: WI] = dataTab[5];
        #3 checkEq("credNoCombPath", reqReady, 0);
        checkEq("credFifoFull", respValid, 4'b0100);
        @(negedge clock); respReady = '0;
        for (int c = 0; c < 8; c++) begin
            #3 checkEq("credRefill", reqReady[2], c == 0);
            @(negedge clock);
        end
        checkEq("credGrantsAfter", grantCnt[2], 3);
        drain("credDrain");

        // grant+pop and write+pop on requester 1
        doReset();
        for (int c = 0; c < 8; c++) begin
            reqValid = 4'b0010;
            reqData[1*WI +: WI] = dataTab[c];
            respReady = (c == 4 || c == 5) ? 4'b0010 : 4'b0000;
            #3;
            case (c)
                0, 1: checkEq("simReady", reqReady[1], 1);
                2, 3: checkEq("simReady", reqReady[1], 0);
                4: begin
                    checkEq("simReady", reqReady[1], 0);
                    checkEq("simRespValid", respValid[1], 1);
                    checkEq("simWriteIncoming", unitOutValid, 1);
                end
                5: begin
                    checkEq("simOccupancyKept", respValid[1], 1);
                    checkEq("simCreditDrop", reqReady[1], 1);
                end
                6: begin
                    checkEq("simFifoEmpty", respValid[1], 0);
                    checkEq("simCreditHeld", reqReady[1], 1);
                end
                default: checkEq("simCreditFull", reqReady[1], 0);
            endcase
            @(negedge clock);
        end
        drain("simDrain");

        // protocol error: result for a full FIFO
        doReset();
        reqData[3*WI +: WI] = dataTab[2];
        for (int c = 0; c < 8; c++) begin
            reqValid = 4'b1000;
            @(negedge clock);
        end
        reqValid = '0;
        #3 checkEq("errBefore", error, 0);
        checkEq("errFifoFull", respValid, 4'b1000);
        @(negedge clock);
        injEn = 1'b1; injValid = 1'b1; injTag = 2'd3; injData = 16'hABCD;
        #3 checkEq("errNotYet", error, 0);
        @(negedge clock);
        injValid = 1'b0; injEn = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #3 checkEq("errSticky", error, 1);
            @(negedge clock);
        end
        drain("errDrain");
        checkEq("errAfterDrain", error, 1);
        doReset();
        #3 checkEq("errCleared", error, 0);

        // out-of-range tag on the three-requester instance
        @(negedge clock);
        unitOutValid3 = 1'b1; unitOutTag3 = 2'd2; unitOutData3 = 16'h1234;
        #3 checkEq("d3Idle", unitInValid3, 0);
        @(negedge clock);
        unitOutTag3 = 2'd3; unitOutData3 = 16'h5678;
        #3 checkEq("d3NoError", error3, 0);
        checkEq("d3RespValid", respValid3, 3'b100);
        checkEq("d3RespData", respData3[2*WO +: WO], 16'h1234);
        @(negedge clock);
        unitOutValid3 = 1'b0;
        #3 checkEq("d3BadTag", error3, 1);
        checkEq("d3DataKept", respData3[2*WO +: WO], 16'h1234);
        checkEq("d3NoGrant", reqReady3, 0);
        @(negedge clock);
        #3 checkEq("d3Sticky", error3, 1);
        checkEq("d3IssueTag", unitInTag3, 0);
        checkEq("d3IssueData", unitInData3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
